l1_cache_ctrl: RTL

- Responder side of the L1 internal request interface. Consumes the registered int_req_* stream issued by the CPU-facing front end and returns int_resp_valid, int_resp_rdata and int_stall.
- Direct-mapped, write-back, write-allocate cache. Tag, valid, dirty and data arrays are held in flops.
- Misses are serviced through a single-beat, line-wide memory port with a valid/ready request channel and a valid-only response channel.

---
 rtl/l1_cache_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/l1_cache_ctrl.sv
// l1_cache_ctrl: direct-mapped write-back L1 responder with line-wide miss port; L1_PERF_CNT_EN adds hit/miss counters
module l1_cache_ctrl #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 4,
  parameter int TAG_BITS    = 22,
  parameter int LINE_BITS   = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 int_req_valid,
  input  logic                 int_req_we,
  input  logic [31:0]          int_req_addr,
  input  logic [31:0]          int_req_wdata,
  input  logic [3:0]           int_req_wstrb,
  output logic                 int_resp_valid,
  output logic [31:0]          int_resp_rdata,
  output logic                 int_stall,
  output logic                 mem_req_valid,
  output logic                 mem_req_we,
  output logic [31:0]          mem_req_addr,
  output logic [LINE_BITS-1:0] mem_req_wdata,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_valid,
  input  logic [LINE_BITS-1:0] mem_resp_rdata
`ifdef L1_PERF_CNT_EN
  ,
  output logic [31:0]          perf_hits,
  output logic [31:0]          perf_misses
`endif
);
  localparam int LINES = 1 << INDEX_BITS;
  typedef enum logic [1:0] {IDLE, WB_REQ, RF_REQ, RF_WAIT} state_t;
  state_t state_q, state_d;
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_BITS-1:0] tag_q [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];
  logic [31:0] miss_addr;
  logic [OFFSET_BITS-3:0] word;
  logic [INDEX_BITS-1:0] idx, miss_idx;
  logic [TAG_BITS-1:0] tag;
  logic hit, acc, miss, victim_dirty, fill;
  logic [31:0] cur_word, merged;
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^int_req_addr[1:0];
  assign word = int_req_addr[OFFSET_BITS-1:2];
  assign idx = int_req_addr[OFFSET_BITS +: INDEX_BITS];
  assign tag = int_req_addr[31 -: TAG_BITS];
  assign miss_idx = miss_addr[OFFSET_BITS +: INDEX_BITS];
  assign hit = valid_q[idx] && tag_q[idx] == tag;
  assign acc = state_q == IDLE && int_req_valid && hit;
  assign miss = state_q == IDLE && int_req_valid && !hit;
  assign victim_dirty = valid_q[idx] && dirty_q[idx];
  assign fill = state_q == RF_WAIT && mem_resp_valid;
  assign int_stall = state_q != IDLE || (int_req_valid && !hit);
  assign cur_word = data_q[idx][{word, 5'b0} +: 32];
  // Byte-merge store data into the addressed word
  always_comb begin
    merged = cur_word;
    for (int b = 0; b < 4; b++)
      if (int_req_wstrb[b]) merged[8*b +: 8] = int_req_wdata[8*b +: 8];
  end
  // Miss sequencing: optional writeback, then refill, then replay in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (miss) state_d = victim_dirty ? WB_REQ : RF_REQ;
      WB_REQ:  if (mem_req_ready) state_d = RF_REQ;
      RF_REQ:  if (mem_req_ready) state_d = RF_WAIT;
      RF_WAIT: if (mem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Control state, valid/dirty bits, response and memory request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      valid_q        <= '0;
      dirty_q        <= '0;
      int_resp_valid <= 1'b0;
      int_resp_rdata <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_we     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_wdata  <= '0;
      miss_addr      <= '0;
    end else begin
      state_q        <= state_d;
      int_resp_valid <= acc;
      if (acc) int_resp_rdata <= int_req_we ? merged : cur_word;
      if (acc && int_req_we) dirty_q[idx] <= 1'b1;
      if (miss) begin
        miss_addr     <= {tag, idx, {OFFSET_BITS{1'b0}}};
        mem_req_valid <= 1'b1;
        mem_req_we    <= victim_dirty;
        mem_req_addr  <= victim_dirty ? {tag_q[idx], idx, {OFFSET_BITS{1'b0}}} : {tag, idx, {OFFSET_BITS{1'b0}}};
        mem_req_wdata <= data_q[idx];
      end
      if (state_q == WB_REQ && mem_req_ready) begin
        dirty_q[miss_idx] <= 1'b0;
        mem_req_we        <= 1'b0;
        mem_req_addr      <= miss_addr;
      end
      if (state_q == RF_REQ && mem_req_ready) mem_req_valid <= 1'b0;
      if (fill) begin
        valid_q[miss_idx] <= 1'b1;
        dirty_q[miss_idx] <= 1'b0;
      end
    end
  end
  // Tag and data storage; contents are qualified by valid so need no reset
  always_ff @(posedge clk) begin
    if (acc && int_req_we) data_q[idx][{word, 5'b0} +: 32] <= merged;
    if (fill) begin
      data_q[miss_idx] <= mem_resp_rdata;
      tag_q[miss_idx]  <= miss_addr[31 -: TAG_BITS];
    end
  end
`ifdef L1_PERF_CNT_EN
  logic replay;
  // Saturating counters; the replayed hit after a refill is not counted as a hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      replay      <= 1'b0;
      perf_hits   <= '0;
      perf_misses <= '0;
    end else begin
      if (miss) replay <= 1'b1;
      else if (acc) replay <= 1'b0;
      if (miss && ~&perf_misses) perf_misses <= perf_misses + 32'd1;
      if (acc && !replay && ~&perf_hits) perf_hits <= perf_hits + 32'd1;
    end
  end
`endif
endmodule
